// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 sequencer: opcodes, FSM states, mux selects.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package td4_pkg;

   // Opcodes: upper nibble of the instruction byte
   localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
   localparam logic [3:0] OP_IN_A     = 4'b0010;
   localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
   localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
   localparam logic [3:0] OP_IN_B     = 4'b0110;
   localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
   localparam logic [3:0] OP_OUT_B    = 4'b1001;
   localparam logic [3:0] OP_OUT_IM   = 4'b1011;
   localparam logic [3:0] OP_JNC_IM   = 4'b1110;
   localparam logic [3:0] OP_JMP_IM   = 4'b1111;

   // Datapath mux source select
   localparam logic [1:0] SEL_A    = 2'd0;
   localparam logic [1:0] SEL_B    = 2'd1;
   localparam logic [1:0] SEL_IN   = 2'd2;
   localparam logic [1:0] SEL_ZERO = 2'd3;

   // ST_HOLD is only reachable when single-stepping is compiled in
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // Decoded control word; imm_en says whether the immediate field reaches the adder
   typedef struct packed {
      logic [1:0] sel;
      logic       ld_a;
      logic       ld_b;
      logic       ld_out;
      logic       ld_pc;
      logic       pc_inc;
      logic       imm_en;
   } ctrl_t;

endpackage

// File: rtl/td4_decoder.sv
// Purpose: combinational opcode + carry flag -> sel / loads / pc_inc / immediate-enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports: op (opcode), carry_flag (registered carry), ctrl (control word).
module td4_decoder
   import td4_pkg::*;
#(
   parameter int OP_W = 4
) (
   input  logic [OP_W-1:0] op,
   input  logic            carry_flag,
   output ctrl_t           ctrl
);

   always_comb begin
      // Default is NOP: advance the PC, no register load
      ctrl        = '0;
      ctrl.sel    = SEL_A;
      ctrl.pc_inc = 1'b1;
      case (op)
         OP_W'(OP_ADD_A_IM): begin ctrl.sel = SEL_A;    ctrl.ld_a   = 1'b1; ctrl.imm_en = 1'b1; end
         OP_W'(OP_ADD_B_IM): begin ctrl.sel = SEL_B;    ctrl.ld_b   = 1'b1; ctrl.imm_en = 1'b1; end
         OP_W'(OP_MOV_A_IM): begin ctrl.sel = SEL_ZERO; ctrl.ld_a   = 1'b1; ctrl.imm_en = 1'b1; end
         OP_W'(OP_MOV_B_IM): begin ctrl.sel = SEL_ZERO; ctrl.ld_b   = 1'b1; ctrl.imm_en = 1'b1; end
         OP_W'(OP_MOV_A_B):  begin ctrl.sel = SEL_B;    ctrl.ld_a   = 1'b1; end
         OP_W'(OP_MOV_B_A):  begin ctrl.sel = SEL_A;    ctrl.ld_b   = 1'b1; end
         OP_W'(OP_IN_A):     begin ctrl.sel = SEL_IN;   ctrl.ld_a   = 1'b1; end
         OP_W'(OP_IN_B):     begin ctrl.sel = SEL_IN;   ctrl.ld_b   = 1'b1; end
         OP_W'(OP_OUT_B):    begin ctrl.sel = SEL_B;    ctrl.ld_out = 1'b1; end
         OP_W'(OP_OUT_IM):   begin ctrl.sel = SEL_ZERO; ctrl.ld_out = 1'b1; ctrl.imm_en = 1'b1; end
         OP_W'(OP_JMP_IM): begin
            ctrl.sel    = SEL_ZERO;
            ctrl.ld_pc  = 1'b1;
            ctrl.pc_inc = 1'b0;
            ctrl.imm_en = 1'b1;
         end
         OP_W'(OP_JNC_IM): begin
            // Branch on the flag left by the previous instruction
            if (!carry_flag) begin
               ctrl.sel    = SEL_ZERO;
               ctrl.ld_pc  = 1'b1;
               ctrl.pc_inc = 1'b0;
               ctrl.imm_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/td4_sequencer.sv
// Purpose: TD4 fetch/exec sequencer: fetches from ROM, decodes IR, drives datapath enables, owns carry flag.
// Latency: 2 cycles per instruction (+1 per ROM ack wait; +1 HOLD cycle when TD4_STEP_EN is defined).
// Backpressure: stalls in FETCH until rom_ack; with TD4_STEP_EN, parks in HOLD until step.
// Ports: clk/clr_n, rom_req/rom_ack/rom_data fetch handshake, carry_in from adder,
//        ld_a/ld_b/ld_out/ld_pc/pc_inc/sel/imm datapath controls, carry_flag, busy, step (TD4_STEP_EN only).
module td4_sequencer
   import td4_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int OP_W   = 4
) (
   input  logic                   clk,
   input  logic                   clr_n,
   output logic                   rom_req,
   input  logic                   rom_ack,
   input  logic [OP_W+DATA_W-1:0] rom_data,
   input  logic                   carry_in,
   output logic                   ld_a,
   output logic                   ld_b,
   output logic                   ld_out,
   output logic                   ld_pc,
   output logic                   pc_inc,
   output logic [1:0]             sel,
   output logic [DATA_W-1:0]      imm,
   output logic                   carry_flag,
`ifdef TD4_STEP_EN
   input  logic                   step,
`endif
   output logic                   busy
);

   state_t                 state;
   state_t                 state_nxt;
   logic [OP_W+DATA_W-1:0] ir;
   ctrl_t                  dec;

   td4_decoder #(.OP_W(OP_W)) u_decoder (
      .op         (ir[DATA_W +: OP_W]),
      .carry_flag (carry_flag),
      .ctrl       (dec)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state      <= ST_IDLE;
         ir         <= '0;
         carry_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_FETCH && rom_ack)
            ir <= rom_data;
         // Every instruction latches the adder carry, whether or not it used the adder
         if (state == ST_EXEC)
            carry_flag <= carry_in;
      end
   end

   always_comb begin
      state_nxt = state;
      rom_req   = 1'b0;
      busy      = 1'b0;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      ld_out    = 1'b0;
      ld_pc     = 1'b0;
      pc_inc    = 1'b0;
      sel       = SEL_A;
      imm       = '0;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            rom_req = 1'b1;
            busy    = 1'b1;
            if (rom_ack)
               state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            busy   = 1'b1;
            ld_a   = dec.ld_a;
            ld_b   = dec.ld_b;
            ld_out = dec.ld_out;
            ld_pc  = dec.ld_pc;
            pc_inc = dec.pc_inc;
            sel    = dec.sel;
            imm    = dec.imm_en ? ir[DATA_W-1:0] : '0;
`ifdef TD4_STEP_EN
            state_nxt = ST_HOLD;
`else
            state_nxt = ST_FETCH;
`endif
         end
         ST_HOLD: begin
`ifdef TD4_STEP_EN
            if (step)
               state_nxt = ST_FETCH;
`else
            state_nxt = ST_FETCH;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
